load_store_unit: RTL and testbench

Memory-stage load/store unit for the pipeline. It accepts one decoded single-data-transfer request at a time (base, offset, up/down, pre/post indexing, writeback, byte/word, load/store) and computes the effective address. It runs a request/acknowledge transaction on the data-memory port and returns load data and the updated base to the register-file write ports. While a transfer is outstanding it holds the fetch/decode stages through `stall`.

---
 rtl/load_store_unit.sv | 145 ++++++++++++++
 tb/tb_load_store_unit.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// Memory-stage load/store unit: effective-address generation, one req/ack memory transaction, load and base writeback.
// Optional watchdog abort of a stuck REQ phase is enabled by defining LSU_WATCHDOG_EN.
module load_store_unit #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_wr,
  input  logic        req_add,
  input  logic        req_pre,
  input  logic        req_wback,
  input  logic        req_byte,
  input  logic [31:0] req_base,
  input  logic [31:0] req_offset,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_rd,
  input  logic [3:0]  req_rn,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic        wb_valid,
  output logic [3:0]  wb_addr,
  output logic [31:0] wb_data,
  output logic        base_wb_valid,
  output logic [3:0]  base_wb_addr,
  output logic [31:0] base_wb_data,
  output logic        stall,
  output logic        err
);

  typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

  state_t      state_q, state_d;
  logic [31:0] ea, accessAddr;
  logic        wr_q, byte_q, baseWb_q;
  logic [31:0] addr_q, wdata_q, ea_q, rdata_q;
  logic [3:0]  be_q, rd_q, rn_q;
  logic [7:0]  loadByte;
  logic        timeout, abort, inReq, inDone;

  assign ea         = req_add ? (req_base + req_offset) : (req_base - req_offset);
  assign accessAddr = req_pre ? ea : req_base;

`ifdef LSU_WATCHDOG_EN
  logic [31:0] cnt_q;
  logic        abort_q;

  assign timeout = (state_q == REQ) && !mem_ack && (cnt_q == 32'(TIMEOUT_CYCLES - 1));
  assign abort   = abort_q;

  // abort_q remembers whether the REQ cycle that led into DONE was a timeout
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      abort_q <= 1'b0;
    end else begin
      cnt_q   <= (state_q == REQ) ? cnt_q + 32'd1 : '0;
      abort_q <= timeout;
    end
  end
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT_CYCLES;
  assign timeout        = 1'b0;
  assign abort          = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (req_valid) state_d = REQ;
      REQ:     if (mem_ack || timeout) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Bus-side address, enables and data are formatted once at capture so they stay stable through REQ
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q     <= 1'b0;
      byte_q   <= 1'b0;
      baseWb_q <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      ea_q     <= '0;
      rdata_q  <= '0;
      be_q     <= '0;
      rd_q     <= '0;
      rn_q     <= '0;
    end else begin
      if (state_q == IDLE && req_valid) begin
        wr_q     <= req_wr;
        byte_q   <= req_byte;
        baseWb_q <= !req_pre || req_wback;
        ea_q     <= ea;
        rd_q     <= req_rd;
        rn_q     <= req_rn;
        if (req_byte) begin
          addr_q  <= accessAddr;
          be_q    <= 4'b0001 << accessAddr[1:0];
          wdata_q <= {4{req_wdata[7:0]}};
        end else begin
          addr_q  <= {accessAddr[31:2], 2'b00};
          be_q    <= 4'hF;
          wdata_q <= req_wdata;
        end
      end
      if (state_q == REQ && mem_ack) rdata_q <= mem_rdata;
    end
  end

  assign loadByte = rdata_q[{addr_q[1:0], 3'b000} +: 8];
  assign inReq    = (state_q == REQ);
  assign inDone   = (state_q == DONE) && !abort;

  assign req_ready     = (state_q == IDLE);
  assign stall         = (state_q != IDLE);
  assign err           = (state_q == DONE) && abort;
  assign mem_req       = inReq;
  assign mem_we        = inReq && wr_q;
  assign mem_addr      = inReq ? addr_q : '0;
  assign mem_be        = inReq ? be_q : '0;
  assign mem_wdata     = inReq ? wdata_q : '0;

  // A load into its own base register keeps the loaded value, so the base update is dropped
  assign wb_valid      = inDone && !wr_q;
  assign wb_addr       = wb_valid ? rd_q : '0;
  assign wb_data       = !wb_valid ? '0 : (byte_q ? {24'h0, loadByte} : rdata_q);
  assign base_wb_valid = inDone && baseWb_q && !(!wr_q && (rd_q == rn_q));
  assign base_wb_addr  = base_wb_valid ? rn_q : '0;
  assign base_wb_data  = base_wb_valid ? ea_q : '0;

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: table of single transfers plus reset, idle-ack and watchdog sequences.
module tb_load_store_unit;

  logic        clk, rst_n;
  logic        req_valid, req_ready, req_wr, req_add, req_pre, req_wback, req_byte;
  logic [31:0] req_base, req_offset, req_wdata;
  logic [3:0]  req_rd, req_rn;
  logic        mem_req, mem_we, mem_ack;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_be;
  logic        wb_valid, base_wb_valid, stall, err;
  logic [3:0]  wb_addr, base_wb_addr;
  logic [31:0] wb_data, base_wb_data;

  int testsRun = 0;
  int testsFailed = 0;

  load_store_unit #(.TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_wr(req_wr), .req_add(req_add),
    .req_pre(req_pre), .req_wback(req_wback), .req_byte(req_byte),
    .req_base(req_base), .req_offset(req_offset), .req_wdata(req_wdata),
    .req_rd(req_rd), .req_rn(req_rn),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
    .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_data(wb_data),
    .base_wb_valid(base_wb_valid), .base_wb_addr(base_wb_addr), .base_wb_data(base_wb_data),
    .stall(stall), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        wr, add, pre, wback, isByte;
    logic [31:0] base, offset, wdata;
    logic [3:0]  rd, rn;
    int          ackDelay;
    logic [31:0] rdata;
    logic [31:0] expAddr;
    logic [3:0]  expBe;
    logic [31:0] expWdata;
    logic        expWb;
    logic [31:0] expWbData;
    logic        expBaseWb;
    logic [31:0] expBaseData;
  } vec_t;

  vec_t vecs[8];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    testsRun++;
    if (act !== exp) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic driveRequest(input vec_t v);
    req_valid  = 1'b1;
    req_wr     = v.wr;
    req_add    = v.add;
    req_pre    = v.pre;
    req_wback  = v.wback;
    req_byte   = v.isByte;
    req_base   = v.base;
    req_offset = v.offset;
    req_wdata  = v.wdata;
    req_rd     = v.rd;
    req_rn     = v.rn;
  endtask

  // One full transfer: accept, REQ with ackDelay idle cycles, ack, DONE, back to IDLE
  task automatic applyStimulus(input int idx, input vec_t v);
    string tag;
    tag = $sformatf("v%0d", idx);
    driveRequest(v);
    checkOutput({tag, ".ready"}, 32'(req_ready), 32'd1);
    step();
    req_valid = 1'b0;
    req_base  = 32'hFFFF_FFFF;
    req_wdata = 32'h0;
    checkOutput({tag, ".memReq"}, 32'(mem_req), 32'd1);
    checkOutput({tag, ".stall"}, 32'(stall), 32'd1);
    checkOutput({tag, ".readyLow"}, 32'(req_ready), 32'd0);
    for (int i = 0; i < v.ackDelay; i++) step();
    checkOutput({tag, ".addr"}, mem_addr, v.expAddr);
    checkOutput({tag, ".be"}, 32'(mem_be), 32'(v.expBe));
    checkOutput({tag, ".we"}, 32'(mem_we), 32'(v.wr));
    checkOutput({tag, ".wdata"}, mem_wdata, v.expWdata);
    mem_ack   = 1'b1;
    mem_rdata = v.rdata;
    step();
    mem_ack   = 1'b0;
    mem_rdata = 32'hFFFF_FFFF;
    checkOutput({tag, ".doneMemReq"}, 32'(mem_req), 32'd0);
    checkOutput({tag, ".wbValid"}, 32'(wb_valid), 32'(v.expWb));
    if (v.expWb) begin
      checkOutput({tag, ".wbAddr"}, 32'(wb_addr), 32'(v.rd));
      checkOutput({tag, ".wbData"}, wb_data, v.expWbData);
    end
    checkOutput({tag, ".baseWbValid"}, 32'(base_wb_valid), 32'(v.expBaseWb));
    if (v.expBaseWb) begin
      checkOutput({tag, ".baseWbAddr"}, 32'(base_wb_addr), 32'(v.rn));
      checkOutput({tag, ".baseWbData"}, base_wb_data, v.expBaseData);
    end
    checkOutput({tag, ".doneErr"}, 32'(err), 32'd0);
    step();
    checkOutput({tag, ".idleReady"}, 32'(req_ready), 32'd1);
    checkOutput({tag, ".idleWb"}, 32'({wb_valid, base_wb_valid, stall}), 32'd0);
  endtask

  initial begin
    vec_t v;
    // wr add pre wb byte base offset wdata rd rn delay rdata | addr be wdata wb wbData baseWb baseData
    vecs[0] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 32'h0000_1000, 32'h8, 32'h1234_5678, 4'd1, 4'd2, 2, 32'hDEAD_BEEF,
                32'h0000_1008, 4'hF, 32'h1234_5678, 1'b1, 32'hDEAD_BEEF, 1'b1, 32'h0000_1008};
    vecs[1] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_2003, 32'h4, 32'hABCD_EF5A, 4'd3, 4'd6, 0, 32'h0,
                32'h0000_2003, 4'b1000, 32'h5A5A_5A5A, 1'b0, 32'h0, 1'b1, 32'h0000_1FFF};
    vecs[2] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 32'h0000_3000, 32'h2, 32'h0, 4'd5, 4'd6, 1, 32'h1122_3344,
                32'h0000_3002, 4'b0100, 32'h0, 1'b1, 32'h0000_0022, 1'b0, 32'h0};
    vecs[3] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 32'h0000_0100, 32'h10, 32'h0, 4'd4, 4'd4, 0, 32'hCAFE_F00D,
                32'h0000_0110, 4'hF, 32'h0, 1'b1, 32'hCAFE_F00D, 1'b0, 32'h0};
    vecs[4] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0000_4006, 32'h10, 32'h8765_4321, 4'd9, 4'd10, 3, 32'h0,
                32'h0000_3FF4, 4'hF, 32'h8765_4321, 1'b0, 32'h0, 1'b1, 32'h0000_3FF6};
    vecs[5] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 32'hFFFF_FFFC, 32'h8, 32'h0, 4'd11, 4'd12, 0, 32'hAABB_CCDD,
                32'h0000_0004, 4'b0001, 32'h0, 1'b1, 32'h0000_00DD, 1'b0, 32'h0};
    vecs[6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0000_0002, 32'h5, 32'h0, 4'd3, 4'd5, 1, 32'h0102_0304,
                32'h0000_0000, 4'hF, 32'h0, 1'b1, 32'h0102_0304, 1'b1, 32'hFFFF_FFFD};
    vecs[7] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 32'h0000_5001, 32'h1, 32'h0, 4'd7, 4'd7, 0, 32'h9988_7766,
                32'h0000_5001, 4'b0010, 32'h0, 1'b1, 32'h0000_0077, 1'b0, 32'h0};

    rst_n = 1'b0; req_valid = 1'b0; req_wr = 1'b0; req_add = 1'b0; req_pre = 1'b0;
    req_wback = 1'b0; req_byte = 1'b0; req_base = '0; req_offset = '0; req_wdata = '0;
    req_rd = '0; req_rn = '0; mem_ack = 1'b0; mem_rdata = 32'hFFFF_FFFF;
    step();
    step();
    checkOutput("reset.ready", 32'(req_ready), 32'd1);
    checkOutput("reset.outs", 32'({mem_req, mem_we, wb_valid, base_wb_valid, stall, err}), 32'd0);
    checkOutput("reset.addr", mem_addr, 32'h0);
    rst_n = 1'b1;
    step();

    for (int i = 0; i < 8; i++) applyStimulus(i, vecs[i]);

    // An ack while idle must not start or complete anything
    mem_ack = 1'b1;
    mem_rdata = 32'h1357_9BDF;
    step();
    mem_ack = 1'b0;
    checkOutput("idleAck.stall", 32'(stall), 32'd0);
    step();
    checkOutput("idleAck.wb", 32'({wb_valid, base_wb_valid, mem_req}), 32'd0);

    // Reset asserted mid-REQ clears the handshake immediately and nothing is written back
    v = vecs[0];
    driveRequest(v);
    step();
    req_valid = 1'b0;
    step();
    checkOutput("rstMid.preReq", 32'(mem_req), 32'd1);
    rst_n = 1'b0;
    #1;
    checkOutput("rstMid.memReq", 32'(mem_req), 32'd0);
    checkOutput("rstMid.stall", 32'(stall), 32'd0);
    step();
    rst_n = 1'b1;
    mem_ack = 1'b1;
    step();
    mem_ack = 1'b0;
    checkOutput("rstMid.ready", 32'(req_ready), 32'd1);
    checkOutput("rstMid.noWb", 32'({wb_valid, base_wb_valid, stall}), 32'd0);

    // No ack: watchdog abort when enabled, otherwise an indefinite wait
    driveRequest(vecs[2]);
    step();
    req_valid = 1'b0;
`ifdef LSU_WATCHDOG_EN
    for (int i = 1; i <= 16; i++) begin
      checkOutput($sformatf("wdog.req%0d", i), 32'({mem_req, err}), 32'b10);
      step();
    end
    checkOutput("wdog.err", 32'(err), 32'd1);
    checkOutput("wdog.dropReq", 32'(mem_req), 32'd0);
    checkOutput("wdog.noWb", 32'({wb_valid, base_wb_valid}), 32'd0);
    step();
    checkOutput("wdog.errOnce", 32'(err), 32'd0);
    checkOutput("wdog.ready", 32'(req_ready), 32'd1);
`else
    for (int i = 1; i <= 24; i++) begin
      checkOutput($sformatf("noWdog.req%0d", i), 32'({mem_req, err}), 32'b10);
      step();
    end
    mem_ack = 1'b1;
    mem_rdata = 32'h1122_3344;
    step();
    mem_ack = 1'b0;
    checkOutput("noWdog.lateWbData", wb_data, 32'h0000_0022);
    step();
    checkOutput("noWdog.ready", 32'(req_ready), 32'd1);
`endif

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
